// File: rtl/normalize_arbiter_if.sv
// Handshake bundle for normalize_arbiter: two operand requesters and one result consumer.
// master = requester/consumer side, slave = the normalizer.
interface normalize_arbiter_if #(
  parameter int WIDTH = 24,
  parameter int CNT_W = 5
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_data;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_data;
  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] resp_data;
  logic [CNT_W-1:0] resp_count;
  logic             resp_zero;
  logic             resp_id;

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, resp_ready,
    input  req0_ready, req1_ready, resp_valid, resp_data, resp_count, resp_zero, resp_id
  );

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, resp_ready,
    output req0_ready, req1_ready, resp_valid, resp_data, resp_count, resp_zero, resp_id
  );
endinterface

// File: rtl/normalize_arbiter.sv
// Two-requester round-robin front end feeding a 2-stage leading-zero normalizer.
// Stage A captures the granted operand; stage B registers the shifted result.
module normalize_arbiter #(
  parameter int WIDTH = 24,
  parameter int CNT_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  normalize_arbiter_if.slave bus
);

  logic             rr_q, rr_d;
  logic             a_valid_q, a_valid_d;
  logic [WIDTH-1:0] a_data_q, a_data_d;
  logic             a_id_q, a_id_d;
  logic             resp_valid_q, resp_valid_d;
  logic [WIDTH-1:0] resp_data_q, resp_data_d;
  logic [CNT_W-1:0] resp_count_q, resp_count_d;
  logic             resp_zero_q, resp_zero_d;
  logic             resp_id_q, resp_id_d;

  logic             grant0, grant1;
  logic             move_b, can_a;
  logic             acc0, acc1;
  logic [CNT_W-1:0] lz_count;

  // rr names the requester that wins when both are valid.
  always_comb begin
    grant0 = bus.req0_valid && (!bus.req1_valid || !rr_q);
    grant1 = bus.req1_valid && (!bus.req0_valid ||  rr_q);
  end

  assign move_b = !resp_valid_q || bus.resp_ready;
  // Readies are forced low while reset is held so nothing is accepted into a clearing pipe.
  assign can_a  = (!a_valid_q || move_b) && !reset;

  assign bus.req0_ready = can_a && grant0;
  assign bus.req1_ready = can_a && grant1;

  assign acc0 = bus.req0_valid && bus.req0_ready;
  assign acc1 = bus.req1_valid && bus.req1_ready;

  // Leading-zero count: the highest set bit wins since the scan runs LSB to MSB.
  always_comb begin
    lz_count = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (a_data_q[i]) begin
        lz_count = CNT_W'(WIDTH - 1 - i);
      end
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (acc0) begin
      rr_d = 1'b1;
    end else if (acc1) begin
      rr_d = 1'b0;
    end
  end

  always_comb begin
    a_valid_d = a_valid_q;
    a_data_d  = a_data_q;
    a_id_d    = a_id_q;
    if (can_a) begin
      a_valid_d = acc0 || acc1;
      if (acc1) begin
        a_data_d = bus.req1_data;
        a_id_d   = 1'b1;
      end else if (acc0) begin
        a_data_d = bus.req0_data;
        a_id_d   = 1'b0;
      end
    end
  end

  // Stage B only reloads on a move; with no new operand it just drops valid.
  always_comb begin
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_count_d = resp_count_q;
    resp_zero_d  = resp_zero_q;
    resp_id_d    = resp_id_q;
    if (move_b) begin
      resp_valid_d = a_valid_q;
      if (a_valid_q) begin
        resp_data_d  = a_data_q << lz_count;
        resp_count_d = lz_count;
        resp_zero_d  = (a_data_q == '0);
        resp_id_d    = a_id_q;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_q         <= 1'b0;
      a_valid_q    <= 1'b0;
      a_data_q     <= '0;
      a_id_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_count_q <= '0;
      resp_zero_q  <= 1'b0;
      resp_id_q    <= 1'b0;
    end else begin
      rr_q         <= rr_d;
      a_valid_q    <= a_valid_d;
      a_data_q     <= a_data_d;
      a_id_q       <= a_id_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_count_q <= resp_count_d;
      resp_zero_q  <= resp_zero_d;
      resp_id_q    <= resp_id_d;
    end
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_count = resp_count_q;
  assign bus.resp_zero  = resp_zero_q;
  assign bus.resp_id    = resp_id_q;

endmodule

// File: tb/tb_normalize_arbiter.sv
// Randomized bench for normalize_arbiter (WIDTH=8, CNT_W=4) against a queue-based
// reference model of in-flight operations, plus directed boundary scenarios.
module tb_normalize_arbiter;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             id;
    int               acc_edge;
  } item_t;

  logic clk = 1'b0;
  logic reset;

  normalize_arbiter_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  normalize_arbiter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  item_t q[$];
  int    edge_cnt = 0;
  logic  pref = 1'b0;
  logic  p0 = 1'b0, p1 = 1'b0;
  logic [WIDTH-1:0] d0 = '0, d1 = '0;
  int    prob0 = 0, prob1 = 0, rdy_prob = 100;
  int    n_results = 0, n_acc = 0;
  logic [WIDTH-1:0] last_data;
  logic [CNT_W-1:0] last_count;
  logic  last_zero, last_id, last_acc_id;
  logic  alt_mode = 1'b0, have_prev = 1'b0, prev_id = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  function automatic logic [CNT_W-1:0] ref_lz(input logic [WIDTH-1:0] v);
    int n = 0;
    while (n < WIDTH && v[WIDTH-1-n] == 1'b0) n++;
    return CNT_W'(n);
  endfunction

  // One clock cycle: drive at the falling edge, check just after, then commit at the rising edge.
  task automatic cycle();
    logic a0, a1, rt, exp_rv, exp_any, rdy;
    if (!p0 && $urandom_range(99) < prob0) begin p0 = 1'b1; d0 = WIDTH'($urandom); end
    if (!p1 && $urandom_range(99) < prob1) begin p1 = 1'b1; d1 = WIDTH'($urandom); end
    rdy = ($urandom_range(99) < rdy_prob);
    @(negedge clk);
    bus.req0_valid = p0; bus.req0_data = d0;
    bus.req1_valid = p1; bus.req1_data = d1;
    bus.resp_ready = rdy;
    #1;
    // Occupancy of at most 1 always leaves room; with 2 in flight, room only if the result leaves.
    exp_any = (p0 || p1) && (q.size() < 2 || rdy);
    check("ready_any", bus.req0_ready | bus.req1_ready, exp_any);
    check("ready_excl", bus.req0_ready & bus.req1_ready, 0);
    if (exp_any) check("grant0", bus.req0_ready, p0 && (!p1 || !pref));
    exp_rv = (q.size() > 0) && (edge_cnt > q[0].acc_edge);
    check("resp_valid", bus.resp_valid, exp_rv);
    if (exp_rv && bus.resp_valid) begin
      check("resp_data",  bus.resp_data,  q[0].data << ref_lz(q[0].data));
      check("resp_count", bus.resp_count, ref_lz(q[0].data));
      check("resp_zero",  bus.resp_zero,  q[0].data == '0);
      check("resp_id",    bus.resp_id,    q[0].id);
    end
    a0 = bus.req0_valid && bus.req0_ready;
    a1 = bus.req1_valid && bus.req1_ready;
    rt = bus.resp_valid && rdy;
    if (rt) begin
      $display("result id=%0d data=%h count=%0d zero=%0d", bus.resp_id, bus.resp_data,
               bus.resp_count, bus.resp_zero);
      if (alt_mode && have_prev) check("alternate", bus.resp_id, !prev_id);
      have_prev  = 1'b1;
      prev_id    = bus.resp_id;
      last_data  = bus.resp_data;
      last_count = bus.resp_count;
      last_zero  = bus.resp_zero;
      last_id    = bus.resp_id;
      n_results++;
    end
    @(posedge clk);
    edge_cnt++;
    if (rt && q.size() > 0) void'(q.pop_front());
    if (a0) begin q.push_back('{data: d0, id: 1'b0, acc_edge: edge_cnt}); pref = 1'b1; p0 = 1'b0; last_acc_id = 1'b0; n_acc++; end
    if (a1) begin q.push_back('{data: d1, id: 1'b1, acc_edge: edge_cnt}); pref = 1'b0; p1 = 1'b0; last_acc_id = 1'b1; n_acc++; end
  endtask

  task automatic clear_last();
    last_data = 'x; last_count = 'x; last_zero = 1'bx; last_id = 1'bx;
  endtask

  initial begin
    int n0, a_before, guard;
    reset = 1'b1;
    bus.req0_valid = 1'b0; bus.req0_data = '0;
    bus.req1_valid = 1'b0; bus.req1_data = '0;
    bus.resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_resp_data",  bus.resp_data, 0);
    check("rst_resp_count", bus.resp_count, 0);
    check("rst_ready0",     bus.req0_ready, 0);
    check("rst_ready1",     bus.req1_ready, 0);
    @(negedge clk);
    reset = 1'b0;

    // Single operand 0x13 from requester 0.
    clear_last();
    p0 = 1'b1; d0 = 8'h13; rdy_prob = 100;
    repeat (4) cycle();
    check("d13_data", last_data, 8'h98);
    check("d13_count", last_count, 3);
    check("d13_zero", last_zero, 0);
    check("d13_id", last_id, 0);

    // All-zero operand from requester 1, then 0x80 from requester 0.
    clear_last();
    p1 = 1'b1; d1 = 8'h00;
    repeat (4) cycle();
    check("d00_data", last_data, 8'h00);
    check("d00_count", last_count, 8);
    check("d00_zero", last_zero, 1);
    check("d00_id", last_id, 1);
    clear_last();
    p0 = 1'b1; d0 = 8'h80;
    repeat (4) cycle();
    check("d80_data", last_data, 8'h80);
    check("d80_count", last_count, 0);
    check("d80_zero", last_zero, 0);

    // Both requesters saturated: alternating ids, one result per cycle.
    prob0 = 100; prob1 = 100; rdy_prob = 100;
    n0 = n_results; alt_mode = 1'b1; have_prev = 1'b0;
    repeat (20) cycle();
    alt_mode = 1'b0;
    check("throughput", (n_results - n0) >= 18, 1);

    // Consumer stalls five cycles with both streams still pushing.
    a_before = n_acc; rdy_prob = 0;
    repeat (5) cycle();
    check("stall_accepts", (n_acc - a_before) <= 2, 1);
    rdy_prob = 100; prob0 = 0; prob1 = 0;
    repeat (8) cycle();
    check("stall_drain", q.size(), 0);

    // Randomized traffic with varying load and back-pressure.
    for (int seg = 0; seg < 30; seg++) begin
      prob0 = $urandom_range(100); prob1 = $urandom_range(100); rdy_prob = $urandom_range(20, 100);
      repeat (100) cycle();
    end
    prob0 = 0; prob1 = 0; rdy_prob = 100;
    repeat (10) cycle();
    check("rand_drain", q.size(), 0);

    // Asynchronous reset with two operations in flight.
    prob0 = 100; prob1 = 100; rdy_prob = 0;
    guard = 0;
    while (q.size() < 2 && guard < 10) begin cycle(); guard++; end
    check("fill_two", q.size(), 2);
    #2;
    reset = 1'b1;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    #1;
    check("arst_resp_valid", bus.resp_valid, 0);
    check("arst_ready0", bus.req0_ready, 0);
    check("arst_ready1", bus.req1_ready, 0);
    q.delete(); pref = 1'b0; p0 = 1'b0; p1 = 1'b0; prob0 = 0; prob1 = 0;
    @(negedge clk);
    reset = 1'b0;
    p0 = 1'b1; d0 = 8'h01; p1 = 1'b1; d1 = 8'h40; rdy_prob = 100;
    last_acc_id = 1'bx;
    cycle();
    check("post_rst_first", last_acc_id, 0);
    repeat (6) cycle();
    check("post_rst_drain", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
